// File: rtl/next186_loader_pkg.sv
// Shared types and defaults for the Next186 BIOS loader.
package next186_loader_pkg;

    localparam int unsigned BIOS_AW        = 13;
    localparam int unsigned BIOS_DW        = 16;
    localparam int unsigned IOCTL_AW       = 25;
    localparam logic [7:0]  BIOS_INDEX_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [BIOS_AW-1:0] addr;
        logic [BIOS_DW-1:0] data;
    } bios_entry_t;

endpackage

// File: rtl/bios_word_fifo.sv
// Synchronous word FIFO for packed BIOS words; pushes while full are ignored.
module bios_word_fifo
    import next186_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  bios_entry_t              i_din,
    output bios_entry_t              o_dout_c,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full_c,
    output logic                     o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    bios_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;
    assign o_dout_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bios_load_sequencer.sv
// Packs the ioctl byte stream into 16-bit BIOS words and drains them to the core on bios_req.
// Optional checksum outputs enabled by defining BIOS_LOAD_CHKSUM_EN.
module bios_load_sequencer
    import next186_loader_pkg::*;
#(
    parameter logic [7:0]  BIOS_INDEX = BIOS_INDEX_DEF,
    parameter int unsigned BIOS_WORDS = 4096,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic                ioctl_wait,
    input  logic                bios_req,
    output logic [12:0]         bios_addr,
    output logic [15:0]         bios_din,
    output logic                bios_wr,
    output logic                bios_done,
    output logic                bios_ovf
`ifdef BIOS_LOAD_CHKSUM_EN
    ,
    output logic [7:0]          bios_sum,
    output logic                bios_sum_ok
`endif
);

    localparam int unsigned         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IOCTL_AW-1:0] ADDR_LIMIT = IOCTL_AW'(2 * BIOS_WORDS);
    localparam logic [CW-1:0]       WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_dl_q;
    logic                w_dl_rise;
    logic                w_dl_fall;
    logic                w_idx_match;
    logic                w_in_range;
    logic                w_byte_acc;
    logic                w_load_entry;
    logic                w_flush_entry;
    logic                w_done_set;
    logic                w_done_nxt;
    logic                r_pending;
    logic [7:0]          r_lo;
    logic [BIOS_AW-1:0]  r_lo_addr;
    logic                w_push_tail;
    logic                w_push_byte;
    logic                w_push_req;
    logic                w_push_ok;
    logic                w_pop;
    bios_entry_t         w_push_data;
    bios_entry_t         w_head;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_nxt;
    logic                w_full;
    logic                w_empty;
    logic                r_wait;
    logic [BIOS_AW-1:0]  r_bios_addr;
    logic [BIOS_DW-1:0]  r_bios_din;
    logic                r_bios_wr;
    logic                r_done;
    logic                r_ovf;

    assign w_idx_match = (ioctl_index == BIOS_INDEX);
    assign w_dl_rise   = ioctl_download & ~r_dl_q;
    assign w_dl_fall   = ~ioctl_download & r_dl_q;
    assign w_in_range  = (ioctl_addr < ADDR_LIMIT);
    assign w_byte_acc  = (r_state == ST_LOAD) & ioctl_wr & ioctl_download & w_idx_match & w_in_range;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus one-cycle entry pulses used by the datapath.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_entry  = 1'b0;
        w_flush_entry = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_dl_rise && w_idx_match) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_dl_fall) begin
                    w_state_nxt   = ST_FLUSH;
                    w_flush_entry = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (w_empty && !r_bios_wr) begin
                    w_state_nxt = ST_DONE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_done_nxt  = w_load_entry ? 1'b0 : (r_done | w_done_set);
    assign w_push_tail = w_flush_entry & r_pending;
    assign w_push_byte = w_byte_acc & ioctl_addr[0];
    assign w_push_req  = w_push_tail | w_push_byte;
    assign w_push_ok   = w_push_req & ~w_full;
    assign w_pop       = bios_req & ~w_empty;
    assign w_count_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);

    // A lone trailing even byte or a lone odd byte gets 8'hFF in the missing half.
    always_comb begin
        w_push_data = '0;
        if (w_push_tail) begin
            w_push_data.addr = r_lo_addr;
            w_push_data.data = {8'hFF, r_lo};
        end else begin
            w_push_data.addr = ioctl_addr[13:1];
            w_push_data.data = {ioctl_dout, (r_pending ? r_lo : 8'hFF)};
        end
    end

    bios_word_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_sys),
        .i_rst_n   (reset_n),
        .i_push    (w_push_req),
        .i_pop     (w_pop),
        .i_din     (w_push_data),
        .o_dout_c  (w_head),
        .o_count   (w_count),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_q      <= 1'b0;
            r_wait      <= 1'b0;
            r_bios_wr   <= 1'b0;
            r_bios_addr <= '0;
            r_bios_din  <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pending   <= 1'b0;
            r_lo        <= '0;
            r_lo_addr   <= '0;
        end else begin
            r_dl_q    <= ioctl_download;
            r_wait    <= (w_count_nxt >= WAIT_LEVEL);
            r_bios_wr <= w_pop;
            r_done    <= w_done_nxt;
            if (w_pop) begin
                r_bios_addr <= w_head.addr;
                r_bios_din  <= w_head.data;
            end
            if (w_load_entry) begin
                r_ovf     <= 1'b0;
                r_pending <= 1'b0;
            end else begin
                if (w_push_req && w_full) begin
                    r_ovf <= 1'b1;
                end
                if (w_push_tail) begin
                    r_pending <= 1'b0;
                end else if (w_byte_acc) begin
                    if (ioctl_addr[0]) begin
                        r_pending <= 1'b0;
                    end else begin
                        r_pending <= 1'b1;
                        r_lo      <= ioctl_dout;
                        r_lo_addr <= ioctl_addr[13:1];
                    end
                end
            end
        end
    end

    assign ioctl_wait = r_wait;
    assign bios_addr  = r_bios_addr;
    assign bios_din   = r_bios_din;
    assign bios_wr    = r_bios_wr;
    assign bios_done  = r_done;
    assign bios_ovf   = r_ovf;

`ifdef BIOS_LOAD_CHKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_nxt;
    logic       r_sum_ok;

    always_comb begin
        w_sum_nxt = r_sum;
        if (w_load_entry) begin
            w_sum_nxt = 8'h00;
        end else if (w_byte_acc) begin
            w_sum_nxt = r_sum + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sum    <= '0;
            r_sum_ok <= 1'b0;
        end else begin
            r_sum    <= w_sum_nxt;
            r_sum_ok <= w_done_nxt & (w_sum_nxt == 8'h00);
        end
    end

    assign bios_sum    = r_sum;
    assign bios_sum_ok = r_sum_ok;
`endif

endmodule

// File: tb/tb_bios_load_sequencer.sv
// Directed bench for bios_load_sequencer: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_bios_load_sequencer;

    logic        clk_sys        = 1'b0;
    logic        reset_n        = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr       = 1'b0;
    logic [24:0] ioctl_addr     = '0;
    logic [7:0]  ioctl_dout     = '0;
    logic [7:0]  ioctl_index    = '0;
    logic        ioctl_wait;
    logic        bios_req       = 1'b0;
    logic [12:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_wr;
    logic        bios_done;
    logic        bios_ovf;
`ifdef BIOS_LOAD_CHKSUM_EN
    logic [7:0]  bios_sum;
    logic        bios_sum_ok;
`endif

    int checks     = 0;
    int errors     = 0;
    int bytes_sent = 0;
    logic [28:0] cap_q [$];

    bios_load_sequencer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .bios_req       (bios_req),
        .bios_addr      (bios_addr),
        .bios_din       (bios_din),
        .bios_wr        (bios_wr),
        .bios_done      (bios_done),
        .bios_ovf       (bios_ovf)
`ifdef BIOS_LOAD_CHKSUM_EN
        ,
        .bios_sum       (bios_sum),
        .bios_sum_ok    (bios_sum_ok)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // Capture every strobed word mid-cycle.
    always @(negedge clk_sys) begin
        if (bios_wr) cap_q.push_back({bios_addr, bios_din});
    end

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] a0;
        int          nb;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          exp_n;
        logic [12:0] exp_a;
        logic [15:0] exp_d;
        logic        exp_done;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [12:0] ea, input logic [15:0] ed);
        logic [28:0] w;
        if (cap_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=none required=%0h/%0h", name, ea, ed);
        end else begin
            w = cap_q.pop_front();
            check(name, 32'(w), {3'b000, ea, ed});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit obey);
        int n;
        n = 0;
        if (obey) begin
            while (ioctl_wait && n < 400) begin
                @(negedge clk_sys);
                n++;
            end
            if (ioctl_wait) begin
                checks++;
                errors++;
                $display("FAIL wait_timeout actual=1 required=0");
            end
        end
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        bytes_sent++;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 25'h0000010, 2, 8'h5A, 8'hA5, 1, 13'h0008, 16'hA55A, 1'b1};
        vecs[1] = '{8'h01, 25'h0000000, 2, 8'h12, 8'h34, 0, 13'h0000, 16'h0000, 1'b1};
        vecs[2] = '{8'h00, 25'h0001FFE, 2, 8'h9C, 8'h3E, 1, 13'h0FFF, 16'h3E9C, 1'b1};
        vecs[3] = '{8'h00, 25'h0002000, 2, 8'h11, 8'h22, 0, 13'h0000, 16'h0000, 1'b1};
        vecs[4] = '{8'h00, 25'h1FFFFFE, 2, 8'h11, 8'h22, 0, 13'h0000, 16'h0000, 1'b1};
        vecs[5] = '{8'h02, 25'h0000002, 2, 8'h11, 8'h22, 0, 13'h0000, 16'h0000, 1'b1};
        vecs[6] = '{8'h00, 25'h0000ABC, 2, 8'h01, 8'h02, 1, 13'h055E, 16'h0201, 1'b1};
        vecs[7] = '{8'h00, 25'h0000020, 1, 8'h77, 8'h00, 1, 13'h0010, 16'hFF77, 1'b1};
        vecs[8] = '{8'h00, 25'h0000031, 1, 8'hC3, 8'h00, 1, 13'h0018, 16'hC3FF, 1'b1};

        // Reset state
        tick(1);
        check("rst_outputs", {bios_addr, bios_din, ioctl_wait, bios_wr, bios_done, bios_ovf}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Basic four-byte image with no-bypass latency
        bios_req = 1'b1;
        cap_q.delete();
        start_dl(8'h00);
        send_byte(25'd0, 8'h11, 1'b0);
        send_byte(25'd1, 8'h22, 1'b0);
        check("lat_no_bypass", bios_wr, 1'b0);
        tick(1);
        check("lat_strobe", bios_wr, 1'b1);
        send_byte(25'd2, 8'h33, 1'b0);
        send_byte(25'd3, 8'h44, 1'b0);
        end_dl();
        tick(10);
        check_word("basic_w0", 13'd0, 16'h2211);
        check_word("basic_w1", 13'd1, 16'h4433);
        check("basic_extra", cap_q.size(), 0);
        check("basic_done", bios_done, 1'b1);
        check("basic_ovf", bios_ovf, 1'b0);
`ifdef BIOS_LOAD_CHKSUM_EN
        check("basic_sum", bios_sum, 8'hAA);
        check("basic_sum_ok", bios_sum_ok, 1'b0);
`endif

        // Odd-length image
        cap_q.delete();
        start_dl(8'h00);
        check("odd_done_clear", bios_done, 1'b0);
        send_byte(25'd0, 8'hAA, 1'b0);
        send_byte(25'd1, 8'hBB, 1'b0);
        send_byte(25'd2, 8'hCC, 1'b0);
        end_dl();
        tick(10);
        check_word("odd_w0", 13'd0, 16'hBBAA);
        check_word("odd_w1", 13'd1, 16'hFFCC);
        check("odd_done", bios_done, 1'b1);

        // Vector table: index/range filter and single-word packing
        for (int v = 0; v < 9; v++) begin
            cap_q.delete();
            start_dl(vecs[v].idx);
            send_byte(vecs[v].a0, vecs[v].d0, 1'b0);
            if (vecs[v].nb == 2) send_byte(vecs[v].a0 + 25'd1, vecs[v].d1, 1'b0);
            end_dl();
            tick(12);
            check($sformatf("vec%0d_count", v), cap_q.size(), vecs[v].exp_n);
            if (vecs[v].exp_n > 0) check_word($sformatf("vec%0d_word", v), vecs[v].exp_a, vecs[v].exp_d);
            check($sformatf("vec%0d_done", v), bios_done, vecs[v].exp_done);
        end

        // Backpressure with an obedient host
        bios_req   = 1'b0;
        bytes_sent = 0;
        cap_q.delete();
        start_dl(8'h00);
        fork
            begin
                for (int i = 0; i < 20; i++) send_byte(25'(i), 8'(i + 1), 1'b1);
            end
            begin
                int n;
                n = 0;
                while (!ioctl_wait && n < 200) begin
                    @(negedge clk_sys);
                    n++;
                end
                check("bp_wait_seen", ioctl_wait, 1'b1);
                check("bp_bytes_at_wait", bytes_sent, 14);
                tick(12);
                check("bp_host_stalled", bytes_sent, 14);
                check("bp_no_output", cap_q.size(), 0);
                bios_req = 1'b1;
            end
        join
        end_dl();
        tick(20);
        for (int i = 0; i < 10; i++) begin
            check_word($sformatf("bp_w%0d", i), 13'(i), {8'(2 * i + 2), 8'(2 * i + 1)});
        end
        check("bp_ovf", bios_ovf, 1'b0);
        check("bp_done", bios_done, 1'b1);

        // Overflow: host ignores ioctl_wait
        bios_req = 1'b0;
        cap_q.delete();
        start_dl(8'h00);
        for (int i = 0; i < 16; i++) send_byte(25'(i), 8'h40 + 8'(i), 1'b0);
        check("ovf_full_no_ovf", bios_ovf, 1'b0);
        for (int i = 16; i < 20; i++) send_byte(25'(i), 8'h40 + 8'(i), 1'b0);
        check("ovf_set", bios_ovf, 1'b1);
        check("ovf_wait", ioctl_wait, 1'b1);
        bios_req = 1'b1;
        end_dl();
        tick(20);
        for (int i = 0; i < 8; i++) begin
            check_word($sformatf("ovf_w%0d", i), 13'(i), {8'h40 + 8'(2 * i + 1), 8'h40 + 8'(2 * i)});
        end
        check("ovf_dropped_absent", cap_q.size(), 0);
        check("ovf_done", bios_done, 1'b1);

        // Reset with five words and a pending byte queued
        bios_req = 1'b0;
        cap_q.delete();
        start_dl(8'h00);
        for (int i = 0; i < 11; i++) send_byte(25'(i), 8'h80 + 8'(i), 1'b0);
        @(negedge clk_sys);
        reset_n        = 1'b0;
        bios_req       = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        check("mid_rst_outputs", {bios_addr, bios_din, ioctl_wait, bios_wr, bios_done, bios_ovf}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check("mid_rst_no_wr", cap_q.size(), 0);
        check("mid_rst_done", bios_done, 1'b0);

        // Fresh download after reset; checksum of 01,FF wraps to zero
        cap_q.delete();
        start_dl(8'h00);
        send_byte(25'd0, 8'h01, 1'b0);
        send_byte(25'd1, 8'hFF, 1'b0);
        end_dl();
        tick(10);
        check_word("post_rst_w0", 13'd0, 16'hFF01);
        check("post_rst_extra", cap_q.size(), 0);
        check("post_rst_done", bios_done, 1'b1);
`ifdef BIOS_LOAD_CHKSUM_EN
        check("sum_zero", bios_sum, 8'h00);
        check("sum_ok", bios_sum_ok, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
